// File: rtl/host_cmd_master.sv
// host_cmd_master: host-side UART command frame initiator; serialises command frames to TX and collects response bytes from RX.
// Optional first-byte response timeout enabled by defining HOST_CMD_TIMEOUT_EN.
module host_cmd_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int GAP_CYCLES     = 2048,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CMD_Valid,
  output logic                    CMD_Ready,
  input  logic [1:0]              CMD_Type,
  input  logic [DATA_WIDTH-1:0]   CMD_Addr,
  input  logic [DATA_WIDTH-1:0]   CMD_Data0,
  input  logic [DATA_WIDTH-1:0]   CMD_Data1,
  input  logic [3:0]              CMD_Fun,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_Valid,
  input  logic                    TX_Busy,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_Valid,
  output logic                    RSP_Valid,
  output logic [2*DATA_WIDTH-1:0] RSP_Data,
  output logic [1:0]              RSP_Len,
  output logic                    RSP_Err
);
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_BUSY, WAIT_DONE, RSP1, RSP2, DONE} state_t;
  localparam logic [CNT_WIDTH-1:0] CNT_SAT = CNT_WIDTH'(GAP_CYCLES > TIMEOUT_CYCLES ? GAP_CYCLES : TIMEOUT_CYCLES);
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] frame_q [4];
  logic [DATA_WIDTH-1:0] frame_d [4];
  logic [1:0] idx_q, idx_d, type_q, type_d;
  logic [2:0] flen_q, flen_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] b1_q, b1_d, b2_q, b2_d;
  logic [2*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0] rsp_len_q, rsp_len_d;
  logic accept, last, gap_hit;
  logic [DATA_WIDTH-1:0] fun_b;
  assign accept  = CMD_Valid && state_q == IDLE;
  assign last    = {1'b0, idx_q} == flen_q - 3'd1;
  assign gap_hit = cnt_q == CNT_WIDTH'(GAP_CYCLES - 1);
  assign fun_b   = {{(DATA_WIDTH-4){1'b0}}, CMD_Fun};
`ifdef HOST_CMD_TIMEOUT_EN
  logic rsp_err_q, rsp_err_d, to_hit;
  assign to_hit  = cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  assign RSP_Err = rsp_err_q;
`else
  assign RSP_Err = 1'b0;
`endif
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      frame_q    <= '{default: '0};
      idx_q      <= '0;
      type_q     <= '0;
      flen_q     <= '0;
      cnt_q      <= '0;
      b1_q       <= '0;
      b2_q       <= '0;
      rsp_data_q <= '0;
      rsp_len_q  <= '0;
`ifdef HOST_CMD_TIMEOUT_EN
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      type_q     <= type_d;
      flen_q     <= flen_d;
      cnt_q      <= cnt_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      rsp_data_q <= rsp_data_d;
      rsp_len_q  <= rsp_len_d;
`ifdef HOST_CMD_TIMEOUT_EN
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = LOAD;
      LOAD:      if (!TX_Busy) state_d = SEND;
      SEND:      state_d = WAIT_BUSY;
      WAIT_BUSY: if (TX_Busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!TX_Busy) state_d = !last ? SEND : type_q == 2'b00 ? DONE : RSP1;
`ifdef HOST_CMD_TIMEOUT_EN
      RSP1:      if (RX_D_Valid) state_d = type_q == 2'b01 ? DONE : RSP2;
                 else if (to_hit) state_d = DONE;
`else
      RSP1:      if (RX_D_Valid) state_d = type_q == 2'b01 ? DONE : RSP2;
`endif
      RSP2:      if (RX_D_Valid || gap_hit) state_d = DONE;
      DONE:      state_d = IDLE;
    endcase
  end
  // Frame bytes are built on accept; unused slots are never transmitted.
  always_comb begin
    frame_d    = frame_q;
    type_d     = type_q;
    flen_d     = flen_q;
    idx_d      = idx_q;
    b1_d       = b1_q;
    b2_d       = b2_q;
    rsp_data_d = rsp_data_q;
    rsp_len_d  = rsp_len_q;
`ifdef HOST_CMD_TIMEOUT_EN
    rsp_err_d  = rsp_err_q;
`endif
    if (accept) begin
      type_d     = CMD_Type;
      flen_d     = CMD_Type == 2'b10 ? 3'd4 : CMD_Type == 2'b00 ? 3'd3 : 3'd2;
      idx_d      = '0;
      b1_d       = '0;
      b2_d       = '0;
      frame_d[0] = CMD_Type == 2'b00 ? DATA_WIDTH'(8'hAA) : CMD_Type == 2'b01 ? DATA_WIDTH'(8'hBB) :
                   CMD_Type == 2'b10 ? DATA_WIDTH'(8'hCC) : DATA_WIDTH'(8'hDD);
      frame_d[1] = CMD_Type[1] ? (CMD_Type[0] ? fun_b : CMD_Data0) : CMD_Addr;
      frame_d[2] = CMD_Type[1] ? CMD_Data1 : CMD_Data0;
      frame_d[3] = fun_b;
    end
    if (state_q == WAIT_DONE && !TX_Busy && !last) idx_d = idx_q + 2'd1;
    if (state_q == RSP1 && RX_D_Valid) b1_d = RX_P_DATA;
    if (state_q == RSP2 && RX_D_Valid) b2_d = RX_P_DATA;
    if (state_d == DONE) begin
      rsp_data_d = {b2_d, b1_d};
      rsp_len_d  = state_q == RSP2 ? (RX_D_Valid ? 2'd2 : 2'd1) : (state_q == RSP1 && RX_D_Valid) ? 2'd1 : 2'd0;
`ifdef HOST_CMD_TIMEOUT_EN
      rsp_err_d  = state_q == RSP1 && !RX_D_Valid;
`endif
    end
    cnt_d = state_d != state_q ? '0 : cnt_q == CNT_SAT ? cnt_q : cnt_q + 1'b1;
  end
  always_comb begin
    CMD_Ready  = state_q == IDLE;
    TX_D_Valid = state_q == SEND;
    TX_P_DATA  = state_q == SEND ? frame_q[idx_q] : '0;
    RSP_Valid  = state_q == DONE;
    RSP_Data   = rsp_data_q;
    RSP_Len    = rsp_len_q;
  end
endmodule

// File: tb/tb_host_cmd_master.sv
// tb_host_cmd_master: scoreboard bench for host_cmd_master with a simple UART TX busy model and directed RX responses.
module tb_host_cmd_master;
  localparam int GAP = 2048;
  logic CLK = 0, RST = 0;
  logic CMD_Valid = 0, CMD_Ready;
  logic [1:0] CMD_Type = 0;
  logic [7:0] CMD_Addr = 0, CMD_Data0 = 0, CMD_Data1 = 0;
  logic [3:0] CMD_Fun = 0;
  logic [7:0] TX_P_DATA;
  logic TX_D_Valid, TX_Busy;
  logic [7:0] RX_P_DATA = 0;
  logic RX_D_Valid = 0;
  logic RSP_Valid;
  logic [15:0] RSP_Data;
  logic [1:0] RSP_Len;
  logic RSP_Err;
  logic model_busy = 0, hold_busy = 0;
  assign TX_Busy = model_busy | hold_busy;

  host_cmd_master #(.DATA_WIDTH(8), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(100), .CNT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .CMD_Valid(CMD_Valid), .CMD_Ready(CMD_Ready), .CMD_Type(CMD_Type),
    .CMD_Addr(CMD_Addr), .CMD_Data0(CMD_Data0), .CMD_Data1(CMD_Data1), .CMD_Fun(CMD_Fun),
    .TX_P_DATA(TX_P_DATA), .TX_D_Valid(TX_D_Valid), .TX_Busy(TX_Busy),
    .RX_P_DATA(RX_P_DATA), .RX_D_Valid(RX_D_Valid), .RSP_Valid(RSP_Valid),
    .RSP_Data(RSP_Data), .RSP_Len(RSP_Len), .RSP_Err(RSP_Err));

  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0, failures = 0, tx_seen = 0, rsp_seen = 0, rx_cyc = 0, rsp_cyc = 0;
  logic [7:0] exp_tx[$];
  logic [18:0] exp_rsp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_tx(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) exp_tx.push_back(w[8*i +: 8]);
  endtask

  function automatic logic [31:0] outs();
    return {2'b0, CMD_Ready, TX_D_Valid, TX_P_DATA, RSP_Valid, RSP_Data, RSP_Len, RSP_Err};
  endfunction

  // Monitor: every TX strobe and response pulse is checked against the queues.
  initial forever begin
    @(negedge CLK);
    if (RST) begin
      if (TX_D_Valid) begin
        if (exp_tx.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected got=%0h exp=none", TX_P_DATA);
        end else check("tx_byte", {24'b0, TX_P_DATA}, {24'b0, exp_tx.pop_front()});
        tx_seen++;
      end
      if (RSP_Valid) begin
        if (exp_rsp.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp_unexpected got=%0h exp=none", {RSP_Err, RSP_Len, RSP_Data});
        end else check("rsp", {13'b0, RSP_Err, RSP_Len, RSP_Data}, {13'b0, exp_rsp.pop_front()});
        rsp_seen++;
        rsp_cyc = cyc;
      end
    end
  end

  initial forever begin
    tick();
    if (TX_D_Valid) begin
      model_busy = 1;
      repeat (4) tick();
      model_busy = 0;
    end
  end

  task automatic issue(input logic [1:0] t, input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1, input logic [3:0] f);
    int n = 0;
    while (!CMD_Ready && n < 1000) begin tick(); n++; end
    check("cmd_ready", {31'b0, CMD_Ready}, 1);
    CMD_Type = t; CMD_Addr = a; CMD_Data0 = d0; CMD_Data1 = d1; CMD_Fun = f; CMD_Valid = 1;
    tick();
    CMD_Valid = 0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    RX_P_DATA = b; RX_D_Valid = 1; rx_cyc = cyc;
    tick();
    RX_D_Valid = 0;
  endtask

  task automatic wait_tx(input int n);
    int t = 0;
    while (tx_seen < n && t < 5000) begin tick(); t++; end
    check("tx_wait", {31'b0, tx_seen >= n}, 1);
  endtask

  task automatic wait_rsp(input int n);
    int t = 0;
    while (rsp_seen < n && t < 5000) begin tick(); t++; end
    check("rsp_wait", {31'b0, rsp_seen >= n}, 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (model_busy && t < 100) begin tick(); t++; end
  endtask

  initial begin
    int r0, t0;
    repeat (3) tick();
    check("reset_outputs", outs(), 32'h2000_0000);
    RST = 1;
    tick();
    // 1: write, first strobe two cycles after accept, no RX wait
    push_tx(32'h00AA053C, 3);
    exp_rsp.push_back({1'b0, 2'd0, 16'h0000});
    issue(2'b00, 8'h05, 8'h3C, 8'h00, 4'h0);
    tick();
    check("t1_latency", {31'b0, TX_D_Valid}, 1);
    wait_rsp(1);
    // 2: read with echo byte during transmission
    push_tx(32'h0000BB06, 2);
    exp_rsp.push_back({1'b0, 2'd1, 16'h005A});
    t0 = tx_seen;
    issue(2'b01, 8'h06, 8'h00, 8'h00, 4'h0);
    wait_tx(t0 + 1);
    rx_byte(8'h11);
    wait_tx(t0 + 2);
    wait_idle();
    repeat (3) tick();
    rx_byte(8'h5A);
    wait_rsp(2);
    // 3: ALU two bytes; response held, CMD_Valid while busy ignored
    push_tx(32'hCCFFFF02, 4);
    exp_rsp.push_back({1'b0, 2'd2, 16'hFE01});
    t0 = tx_seen;
    issue(2'b10, 8'h00, 8'hFF, 8'hFF, 4'h2);
    check("rsp_hold", {16'b0, RSP_Data}, 32'h005A);
    CMD_Type = 2'b00; CMD_Valid = 1;
    tick();
    CMD_Valid = 0;
    wait_tx(t0 + 4);
    wait_idle();
    repeat (2) tick();
    rx_byte(8'h01);
    repeat (5) tick();
    rx_byte(8'hFE);
    wait_rsp(3);
    // 4: ALU one byte, gap expiry
    push_tx(32'h0000DD00, 2);
    exp_rsp.push_back({1'b0, 2'd1, 16'h0007});
    t0 = tx_seen;
    issue(2'b11, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_tx(t0 + 2);
    wait_idle();
    repeat (2) tick();
    rx_byte(8'h07);
    wait_rsp(4);
    check("t4_gap_timing", rsp_cyc - rx_cyc, GAP + 1);
    // 4b: second byte on the expiry cycle is still taken
    push_tx(32'h0000DD05, 2);
    exp_rsp.push_back({1'b0, 2'd2, 16'h4433});
    t0 = tx_seen;
    issue(2'b11, 8'h00, 8'h00, 8'h00, 4'h5);
    wait_tx(t0 + 2);
    wait_idle();
    repeat (2) tick();
    rx_byte(8'h33);
    r0 = rx_cyc;
    repeat (GAP - 1) tick();
    rx_byte(8'h44);
    wait_rsp(5);
    check("t4b_edge_timing", rsp_cyc - r0, GAP + 1);
    // 5: TX_Busy held at accept, then reset mid-frame
    hold_busy = 1;
    push_tx(32'h00AA0977, 3);
    t0 = tx_seen;
    issue(2'b00, 8'h09, 8'h77, 8'h00, 4'h0);
    repeat (50) tick();
    check("t5_busy_hold", tx_seen, t0);
    hold_busy = 0;
    wait_tx(t0 + 1);
    RST = 0;
    #1;
    check("t5_abort_outputs", outs(), 32'h2000_0000);
    exp_tx.delete();
    exp_rsp.delete();
    r0 = rsp_seen;
    repeat (3) tick();
    RST = 1;
    repeat (30) tick();
    check("t5_no_rsp", rsp_seen, r0);
    // 6: read with no RX response
    push_tx(32'h0000BB07, 2);
    t0 = tx_seen;
`ifdef HOST_CMD_TIMEOUT_EN
    exp_rsp.push_back({1'b1, 2'd0, 16'h0000});
    issue(2'b01, 8'h07, 8'h00, 8'h00, 4'h0);
    wait_rsp(rsp_seen + 1);
`else
    r0 = rsp_seen;
    issue(2'b01, 8'h07, 8'h00, 8'h00, 4'h0);
    repeat (10000) tick();
    check("t6_no_timeout", rsp_seen, r0);
    check("t6_tx_sent", tx_seen, t0 + 2);
    RST = 0;
    tick();
    RST = 1;
    tick();
`endif
    check("tx_queue_empty", exp_tx.size(), 0);
    check("rsp_queue_empty", exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
